// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and port ownership.
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Priority selection between fetch and data ports with a fetch anti-starvation counter.
module mem_arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    if_req_i,
    input  logic                    d_req_i,
    input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
    output logic                    sel_valid_o,
    output owner_e                  sel_owner_o,
    output logic [STARVE_CNT_W-1:0] starve_cnt_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    always_comb begin
        sel_valid_o  = if_req_i | d_req_i;
        sel_owner_o  = OWN_NONE;
        starve_cnt_o = starve_cnt_i;
        if (if_req_i && d_req_i) begin
            // Data wins contention until fetch has lost LIMIT times in a row.
            if (starve_cnt_i >= LIMIT) begin
                sel_owner_o  = OWN_IF;
                starve_cnt_o = '0;
            end else begin
                sel_owner_o  = OWN_D;
                starve_cnt_o = starve_cnt_i + 1'b1;
            end
        end else if (if_req_i) begin
            sel_owner_o  = OWN_IF;
            starve_cnt_o = '0;
        end else if (d_req_i) begin
            sel_owner_o  = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one memory port,
// with a single outstanding transaction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e              state_q;
    owner_e                  owner_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    logic                    sel_valid;
    owner_e                  sel_owner;
    logic                    gnt_fire;
    logic                    rsp_fire;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_sel (
        .if_req_i    (if_req),
        .d_req_i     (d_req),
        .starve_cnt_i(starve_cnt_q),
        .sel_valid_o (sel_valid),
        .sel_owner_o (sel_owner),
        .starve_cnt_o(starve_cnt_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        owner_q      <= sel_owner;
                        starve_cnt_q <= starve_cnt_d;
                        mem_req_q    <= 1'b1;
                        state_q      <= ISSUE;
                        if (sel_owner == OWN_D) begin
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid) begin
                        owner_q <= OWN_NONE;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake strobes follow mem_ready/mem_rvalid in the same cycle.
    assign gnt_fire = (state_q == ISSUE) && mem_ready;
    assign rsp_fire = (state_q == WAIT_RESP) && mem_rvalid;

    assign if_gnt   = gnt_fire && (owner_q == OWN_IF);
    assign d_gnt    = gnt_fire && (owner_q == OWN_D);
    assign if_valid = rsp_fire && (owner_q == OWN_IF);
    assign d_valid  = rsp_fire && (owner_q == OWN_D);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_rdata  = d_valid ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned LIM = 4;
    localparam int unsigned NV  = 14;
    localparam logic [63:0] Z   = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Column order: inputs first, then expected outputs.
    typedef struct {
        logic        ifr;  logic [63:0] ifa;
        logic        dr;   logic dwe; logic [63:0] da; logic [63:0] dwd;
        logic        rdy;  logic rv;  logic [63:0] rd;
        logic [1:0]  gnt;  logic [1:0] vld; logic cdr;
        logic [63:0] ifrd; logic [63:0] drd;
        logic        mreq; logic mwe; logic [63:0] maddr; logic [63:0] mwd;
        logic        busy;
    } vec_t;

    vec_t tbl [NV];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [63:0] memm [logic [63:0]];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    task automatic apply_row(input vec_t v);
        if_req = v.ifr; if_addr = v.ifa;
        d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
        mem_ready = v.rdy; mem_rvalid = v.rv; mem_rdata = v.rd;
    endtask

    task automatic chk_row(input int i, input vec_t v, input bit chk_mem);
        chk1($sformatf("vec%0d.if_gnt", i), if_gnt, v.gnt[1]);
        chk1($sformatf("vec%0d.d_gnt", i), d_gnt, v.gnt[0]);
        chk1($sformatf("vec%0d.if_valid", i), if_valid, v.vld[1]);
        chk1($sformatf("vec%0d.d_valid", i), d_valid, v.vld[0]);
        chk64($sformatf("vec%0d.if_rdata", i), if_rdata, v.ifrd);
        if (v.cdr) chk64($sformatf("vec%0d.d_rdata", i), d_rdata, v.drd);
        chk1($sformatf("vec%0d.mem_req", i), mem_req, v.mreq);
        chk1($sformatf("vec%0d.busy", i), busy, v.busy);
        if (chk_mem || v.mreq) begin
            chk1($sformatf("vec%0d.mem_we", i), mem_we, v.mwe);
            chk64($sformatf("vec%0d.mem_addr", i), mem_addr, v.maddr);
            chk64($sformatf("vec%0d.mem_wdata", i), mem_wdata, v.mwd);
        end
    endtask

    // Counts grants over a bounded window; bit k of is_if is 1 when grant k went to fetch.
    task automatic collect(input int n, output logic [31:0] is_if, output int got);
        got   = 0;
        is_if = '0;
        for (int c = 0; c < 3 * n + 6 && got < n; c++) begin
            @(negedge clk);
            chk1("gnt_exclusive", if_gnt & d_gnt, 1'b0);
            if (if_gnt || d_gnt) begin
                is_if[got] = if_gnt;
                got++;
            end
            adv();
        end
    endtask

    function automatic logic [63:0] rd_model(input logic [63:0] a);
        if (memm.exists(a)) return memm[a];
        return {a[31:0], ~a[31:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] order;
        int          got;
        int          streak;
        bit          pend_if, pend_d, win_d;
        logic        e_we;
        logic [63:0] e_addr, e_wd;
        int          stall, wt;

        tbl[0]  = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0};
        tbl[1]  = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b1, 64'h1234,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0};
        tbl[2]  = '{1'b1, 64'h100, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, Z,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0};
        tbl[3]  = '{1'b1, 64'h100, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, Z,
                    2'b10, 2'b00, 1'b1, Z, Z, 1'b1, 1'b0, 64'h100, Z, 1'b1};
        tbl[4]  = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b1, 64'h0050_0093,
                    2'b00, 2'b10, 1'b1, 64'h0050_0093, Z, 1'b0, 1'b0, Z, Z, 1'b1};
        tbl[5]  = '{1'b0, Z, 1'b1, 1'b1, 64'h20, 64'hDEAD, 1'b0, 1'b0, Z,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0};
        tbl[6]  = '{1'b0, Z, 1'b1, 1'b1, 64'h20, 64'hDEAD, 1'b0, 1'b0, Z,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b1, 1'b1, 64'h20, 64'hDEAD, 1'b1};
        tbl[7]  = '{1'b0, Z, 1'b1, 1'b0, 64'h44, 64'hBEEF, 1'b1, 1'b0, Z,
                    2'b01, 2'b00, 1'b1, Z, Z, 1'b1, 1'b1, 64'h20, 64'hDEAD, 1'b1};
        tbl[8]  = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b1, 64'h5555,
                    2'b00, 2'b01, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, 1'b1};
        tbl[9]  = '{1'b0, Z, 1'b1, 1'b0, 64'h20, Z, 1'b0, 1'b1, 64'hFFFF,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0};
        tbl[10] = '{1'b0, Z, 1'b1, 1'b0, 64'h20, Z, 1'b1, 1'b1, 64'h777,
                    2'b01, 2'b00, 1'b1, Z, Z, 1'b1, 1'b0, 64'h20, Z, 1'b1};
        tbl[11] = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b1};
        tbl[12] = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b1, 64'hDEAD,
                    2'b00, 2'b01, 1'b1, Z, 64'hDEAD, 1'b0, 1'b0, Z, Z, 1'b1};
        tbl[13] = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z,
                    2'b00, 2'b00, 1'b1, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0};

        do_reset();

        // Reset state, spurious rvalid, fetch, store, payload glitch, load.
        for (int i = 0; i < NV; i++) begin
            apply_row(tbl[i]);
            @(negedge clk);
            chk_row(i, tbl[i], i < 3);
            adv();
        end

        // Backpressure: five stalled ISSUE cycles, then grant.
        clear_inputs();
        if_req = 1'b1; if_addr = 64'h300;
        @(negedge clk);
        adv();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk1("bp_mem_req", mem_req, 1'b1);
            chk64("bp_mem_addr", mem_addr, 64'h300);
            chk1("bp_if_gnt", if_gnt, 1'b0);
            chk1("bp_busy", busy, 1'b1);
            adv();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk1("bp_gnt_on_ready", if_gnt, 1'b1);
        adv();
        if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hABC;
        @(negedge clk);
        chk1("bp_if_valid", if_valid, 1'b1);
        chk64("bp_if_rdata", if_rdata, 64'hABC);
        adv();
        clear_inputs();

        // Reset during WAIT_RESP after three data wins, then a late rvalid.
        do_reset();
        if_req = 1'b1; if_addr = 64'h400;
        d_req = 1'b1; d_addr = 64'h40; mem_ready = 1'b1; mem_rvalid = 1'b1;
        collect(3, order, got);
        chk64("pre_reset_grants", 64'(got), 64'd3);
        chk64("pre_reset_order", 64'(order[2:0]), 64'd0);
        mem_rvalid = 1'b0; reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk1("wait_busy_before_reset", busy, 1'b1);
        adv();
        reset = 1'b0;
        @(negedge clk);
        chk1("post_reset_busy", busy, 1'b0);
        adv();
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
        @(negedge clk);
        chk1("late_rvalid_if_valid", if_valid, 1'b0);
        chk1("late_rvalid_d_valid", d_valid, 1'b0);
        chk1("late_rvalid_busy", busy, 1'b0);
        adv();

        // Sustained contention: fetch wins every (LIM+1)th grant.
        if_req = 1'b1; d_req = 1'b1;
        collect(10, order, got);
        chk64("cont_grants", 64'(got), 64'd10);
        for (int k = 0; k < 10; k++)
            chk1($sformatf("cont_order[%0d]", k), order[k], (k % (LIM + 1)) == LIM);
        if_req = 1'b0; d_req = 1'b0;
        adv();
        clear_inputs();

        // Randomized traffic against a transaction-level model.
        do_reset();
        streak  = 0;
        pend_if = 1'b0;
        pend_d  = 1'b0;
        for (int t = 0; t < 120; t++) begin
            if (!pend_if && $urandom_range(0, 2) != 0) begin
                pend_if = 1'b1;
                if_addr = 64'($urandom_range(0, 15)) << 3;
            end
            if (!pend_d && $urandom_range(0, 2) != 0) begin
                pend_d  = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 64'($urandom_range(0, 15)) << 3;
                d_wdata = {$urandom, $urandom};
            end
            if_req     = pend_if;
            d_req      = pend_d;
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = {$urandom, $urandom};
            @(negedge clk);
            chk1("rnd_idle_busy", busy, 1'b0);
            chk1("rnd_idle_if_valid", if_valid, 1'b0);
            chk1("rnd_idle_d_valid", d_valid, 1'b0);
            if (!(pend_if || pend_d)) begin
                adv();
                continue;
            end
            win_d = pend_d && !(pend_if && streak == LIM);
            if (!win_d) streak = 0;
            else if (pend_if && streak < LIM) streak++;
            e_we   = win_d ? d_we : 1'b0;
            e_addr = win_d ? d_addr : if_addr;
            e_wd   = win_d ? d_wdata : Z;
            adv();

            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                mem_ready  = (s == stall);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) begin
                    if (win_d) d_req = 1'b0;
                    else if_req = 1'b0;
                end
                @(negedge clk);
                chk1("rnd_mem_req", mem_req, 1'b1);
                chk1("rnd_mem_we", mem_we, e_we);
                chk64("rnd_mem_addr", mem_addr, e_addr);
                chk64("rnd_mem_wdata", mem_wdata, e_wd);
                chk1("rnd_issue_busy", busy, 1'b1);
                chk1("rnd_if_gnt", if_gnt, (s == stall) && !win_d);
                chk1("rnd_d_gnt", d_gnt, (s == stall) && win_d);
                chk1("rnd_issue_if_valid", if_valid, 1'b0);
                chk1("rnd_issue_d_valid", d_valid, 1'b0);
                adv();
            end
            if (win_d) begin pend_d = 1'b0; d_req = 1'b0; end
            else begin pend_if = 1'b0; if_req = 1'b0; end
            if_req = pend_if;
            d_req  = pend_d;

            wt = $urandom_range(0, 3);
            for (int s = 0; s <= wt; s++) begin
                mem_ready  = 1'($urandom_range(0, 1));
                mem_rvalid = (s == wt);
                mem_rdata  = e_we ? {$urandom, $urandom} : rd_model(e_addr);
                @(negedge clk);
                chk1("rnd_wait_mem_req", mem_req, 1'b0);
                chk1("rnd_wait_busy", busy, 1'b1);
                chk1("rnd_wait_if_gnt", if_gnt, 1'b0);
                chk1("rnd_wait_d_gnt", d_gnt, 1'b0);
                chk1("rnd_if_valid", if_valid, (s == wt) && !win_d);
                chk1("rnd_d_valid", d_valid, (s == wt) && win_d);
                if (s == wt) begin
                    if (win_d) begin
                        chk64("rnd_nonowner_if_rdata", if_rdata, Z);
                        if (!e_we) chk64("rnd_d_rdata", d_rdata, rd_model(e_addr));
                    end else begin
                        chk64("rnd_nonowner_d_rdata", d_rdata, Z);
                        chk64("rnd_if_rdata", if_rdata, rd_model(e_addr));
                    end
                end
                adv();
            end
            if (e_we) memm[e_addr] = e_wd;
            mem_rvalid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 64, address width in bits.
REQ-002 SHALL have parameter DATA_W, 64, data width in bits.
REQ-003 SHALL have parameter STARVE_LIMIT, 4, number of consecutive data wins before fetch is forced (range 1-7).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports if_gnt out 1, if_valid out 1, if_rdata out DATA_W: fetch accepted, fetch response strobe, fetch data.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W: load/store request, write flag, address, store data.
REQ-009 SHALL have ports d_gnt out 1, d_valid out 1, d_rdata out DATA_W: data accepted, data response/store-ack strobe, load data.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W: unified-memory request.
REQ-011 SHALL have ports mem_ready in 1, mem_rvalid in 1, mem_rdata in DATA_W: memory accept, response strobe, read data.
REQ-012 SHALL have port busy out 1: high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP; at most one memory transaction outstanding.
REQ-014 IDLE: if any request is high, SHALL select an owner, latch its addr/we/wdata into mem_* registers (fetch: mem_we=0, mem_wdata=0), go to ISSUE; otherwise stay.
REQ-015 Selection SHALL be: only one requester -> that one; both -> data, unless starve_cnt == STARVE_LIMIT, then fetch.
REQ-016 starve_cnt (3 bits) SHALL increment when both request in IDLE and data is selected, clear when fetch is selected, hold otherwise; saturates at STARVE_LIMIT.
REQ-017 ISSUE: mem_req SHALL be 1 with stable mem_addr/mem_we/mem_wdata until mem_ready=1; in that cycle owner's gnt SHALL pulse high for exactly one cycle and FSM goes to WAIT_RESP.
REQ-018 WAIT_RESP: mem_req SHALL be 0; on mem_rvalid=1 owner's valid SHALL pulse one cycle, owner's rdata SHALL equal mem_rdata in that cycle, FSM goes to IDLE.
REQ-019 Stores SHALL complete via d_valid on mem_rvalid; d_rdata content for stores is don't-care.
REQ-020 if_gnt/d_gnt and if_valid/d_valid SHALL never be high simultaneously; non-owner outputs SHALL be 0 (rdata 0).
REQ-021 Requesters SHALL hold req and payload until gnt; payload changes before gnt are ignored (latched copy used).
REQ-022 Minimum latency: req sampled in IDLE at cycle N -> mem_req at N+1 -> gnt at N+1 (if mem_ready) -> valid earliest N+2 -> next arbitration at N+3.
REQ-023 mem_rvalid in IDLE or ISSUE SHALL be ignored (no valid pulse, no state change).
REQ-024 A requester dropping req while in ISSUE SHALL NOT abort the transaction.

Reset
REQ-025 With reset=1 at a rising edge: state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, owner cleared.
REQ-026 While state=IDLE after reset, all gnt/valid outputs, busy and rdata outputs SHALL be 0.
REQ-027 Reset in ISSUE or WAIT_RESP SHALL abandon the transaction; a late mem_rvalid is discarded per REQ-023.

Structure
REQ-028 FSM state encoding and owner encoding (OWN_IF, OWN_D) SHALL live in the shared processor package.
REQ-029 Priority/starvation selection MAY be a sub-module mem_arb_select; everything else in one module.

Verification
REQ-030 Fetch only: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid one cycle later with 0x00500093 -> if_gnt at N+1, if_valid with if_rdata=0x00500093 at N+2.
REQ-031 Store then load: d_we=1, d_addr=0x20, d_wdata=0xDEAD -> mem_we=1, mem_wdata=0xDEAD, d_valid ack; then load 0x20 returns 0xDEAD on d_rdata.
REQ-032 Contention, STARVE_LIMIT=4: if_req and d_req held high continuously -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-033 Backpressure: mem_ready=0 for 5 cycles in ISSUE -> mem_addr stable, no gnt, busy=1; gnt in the cycle mem_ready rises.
REQ-034 Reset in WAIT_RESP, mem_rvalid arrives 2 cycles later -> no if_valid/d_valid, state IDLE, starve_cnt=0.
REQ-035 Spurious mem_rvalid in IDLE -> all outputs remain 0, no state change.
